// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths, index-width helper and FSM states for the RSA decrypt core.
package rsa_pkg;
    localparam int MOD_BIT  = 5;
    localparam int EXPO_BIT = 3;
    function automatic int idx_w_of(input int e);
        return (e > 1) ? $clog2(e) : 1;
    endfunction
    localparam int IDX_W = idx_w_of(EXPO_BIT);
    typedef enum logic [2:0] {IDLE, R2, CM, SQ, MUL, OUT, DONE} state_t;
endpackage

// File: rtl/mont_mul_serial.sv
// mont_mul_serial: bit-serial radix-2 Montgomery product a*b*2^-k mod n in k+2 cycles.
module mont_mul_serial #(
    parameter int k = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [k-1:0] a,
    input  logic [k-1:0] b,
    input  logic [k-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [k-1:0] p
);
    localparam int cw = (k > 1) ? $clog2(k) : 1;
    localparam logic [cw-1:0] last = cw'(k - 1);
    logic          run, fin;
    logic [cw-1:0] cnt;
    logic [k-1:0]  a_r, b_r, n_r;
    logic [k+1:0]  t, t1, t2;
    // T stays below 2n, so T + b + n fits in k+2 bits
    always_comb begin
        t1 = t + (a_r[0] ? {2'b0, b_r} : '0);
        t2 = t1 + (t1[0] ? {2'b0, n_r} : '0);
    end
    assign p    = (t >= {2'b0, n_r}) ? k'(t - {2'b0, n_r}) : t[k-1:0];
    assign busy = run | fin;
    assign done = fin;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
            fin <= 1'b0;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
            t   <= '0;
        end else begin
            fin <= 1'b0;
            if (start && !run && !fin) begin
                a_r <= a;
                b_r <= b;
                n_r <= n;
                t   <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                t   <= t2 >> 1;
                a_r <= a_r >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == last) begin
                    run <= 1'b0;
                    fin <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rsa_decrypt.sv
// rsa_decrypt: m = c^d mod n by left-to-right Montgomery exponentiation with on-chip R and R^2 mod n.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int mod_bit  = MOD_BIT,
    parameter int expo_bit = EXPO_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [mod_bit-1:0]  c,
    input  logic [mod_bit-1:0]  n,
    input  logic [expo_bit-1:0] d,
    output logic [mod_bit-1:0]  m,
    output logic                busy,
    output logic                done
);
    localparam int iw = idx_w_of(expo_bit);
    localparam int rw = $clog2(2 * mod_bit);
    state_t              state;
    logic [mod_bit-1:0]  c_r, n_r, x_m, c_m, t, t_nx, op_a, op_b, p;
    logic [mod_bit:0]    t2;
    logic [expo_bit-1:0] d_r;
    logic [iw-1:0]       idx;
    logic [rw-1:0]       rc;
    logic                issue, mm_busy, mm_done;
    // t doubles mod n; after k steps it is R mod n, after 2k steps R^2 mod n
    always_comb begin
        t2   = {t, 1'b0};
        t_nx = (t2 >= {1'b0, n_r}) ? mod_bit'(t2 - {1'b0, n_r}) : t2[mod_bit-1:0];
        op_a = (state == CM) ? c_r : x_m;
        op_b = (state == CM) ? t : (state == SQ) ? x_m : (state == MUL) ? c_m : mod_bit'(1);
    end
    mont_mul_serial #(.k(mod_bit)) u_mm (
        .clk  (clk),
        .rst  (rst),
        .start(issue && !mm_busy),
        .a    (op_a),
        .b    (op_b),
        .n    (n_r),
        .busy (mm_busy),
        .done (mm_done),
        .p    (p)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            c_r   <= '0;
            n_r   <= '0;
            d_r   <= '0;
            x_m   <= '0;
            c_m   <= '0;
            t     <= '0;
            idx   <= '0;
            rc    <= '0;
            issue <= 1'b0;
            m     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done  <= 1'b0;
            issue <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    c_r   <= c;
                    n_r   <= n;
                    d_r   <= d;
                    idx   <= iw'(expo_bit - 1);
                    t     <= mod_bit'(1);
                    rc    <= '0;
                    busy  <= 1'b1;
                    state <= R2;
                end
                R2: begin
                    t  <= t_nx;
                    rc <= rc + 1'b1;
                    if (rc == rw'(mod_bit - 1)) x_m <= t_nx;
                    if (rc == rw'(2 * mod_bit - 1)) begin
                        issue <= 1'b1;
                        state <= CM;
                    end
                end
                CM: if (mm_done) begin
                    c_m   <= p;
                    issue <= 1'b1;
                    state <= SQ;
                end
                SQ, MUL: if (mm_done) begin
                    x_m   <= p;
                    issue <= 1'b1;
                    if (state == SQ && d_r[idx]) state <= MUL;
                    else if (idx == '0) state <= OUT;
                    else begin
                        idx   <= idx - 1'b1;
                        state <= SQ;
                    end
                end
                OUT: if (mm_done) begin
                    m     <= p;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_decrypt.sv
// tb_rsa_decrypt: randomized and directed checks of rsa_decrypt against a modpow/latency reference model.
module tb_rsa_decrypt;
    localparam int K = 5;
    localparam int E = 3;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [K-1:0] c = '0, n = '0, m;
    logic [E-1:0] d = '0;
    logic         busy, done;
    int           n_chk = 0, n_fail = 0;

    rsa_decrypt dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .c    (c),
        .n    (n),
        .d    (d),
        .m    (m),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic int modpow(input int b, input int e, input int md);
        int r = 1 % md;
        for (int i = 0; i < e; i++) r = (r * b) % md;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: a transaction accepted at E0 finishes L edges later and stays busy one more
    bit mb = 1'b0;
    int cnt = 0, lat_exp = 0, next_m = 0, hold = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb   = 1'b0;
            cnt  = 0;
            hold = 0;
        end else if (!mb) begin
            if (start) begin
                mb      = 1'b1;
                cnt     = 0;
                next_m  = modpow(int'(c), int'(d), int'(n));
                lat_exp = 2 * K + (K + 2) * (2 + E + $countones(d));
            end
        end else begin
            cnt++;
            if (cnt == lat_exp) hold = next_m;
            if (cnt == lat_exp + 1) mb = 1'b0;
        end
    end

    always @(posedge clk) begin
        #3;
        chk("busy", int'(busy), int'(mb));
        chk("done", int'(done), int'(mb && cnt == lat_exp));
        if (!mb || cnt == lat_exp) chk("m", int'(m), hold);
    end

    task automatic go(input int cc, input int nn, input int dd, input int lm, input int ll,
                      input int pa, input int ab);
        int lat = 0;
        c = K'(cc);
        n = K'(nn);
        d = E'(dd);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = (lat == pa);
            if (lat == ab) begin
                rst = 1'b0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_m", int'(m), 0);
                @(negedge clk);
                rst = 1'b1;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        if (!done) chk("timeout", lat, -1);
        if (lm >= 0) chk("lit_m", int'(m), lm);
        if (ll >= 0) chk("lit_latency", lat, ll);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        go(2, 29, 7, 12, 66, -1, -1);
        go(8, 29, 7, 17, 66, -1, -1);
        go(0, 29, 7, 0, 66, -1, -1);
        go(2, 29, 0, 1, 45, -1, -1);
        go(2, 29, 7, 12, 66, 20, -1);
        go(2, 29, 7, -1, -1, -1, 30);
        @(negedge clk);
        go(2, 29, 7, 12, 66, -1, -1);
        for (int i = 0; i < 25; i++) begin
            int rn = 17 + 2 * $urandom_range(0, 7);
            go($urandom_range(0, rn - 1), rn, $urandom_range(0, 7), -1, -1, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
